// File: rtl/chu_timer_sched.sv
// chu_timer_sched: NUM_CH down-counting timeout/alarm channels sharing one prescaled tick,
// with per-channel expiry flags and a registered level interrupt on the MMIO slot bus.
module chu_timer_sched #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);
  localparam logic [16:0] PRE_MAX = 17'(PRESCALE - 1);
  logic [16:0] pre;
  logic tick;
  logic unused_read;
  logic [NUM_CH-1:0][31:0] period_v, count_v;
  logic [NUM_CH-1:0] en_v, periodic_v, ie_v, flag_v;
  assign unused_read = read;
  assign tick = pre == PRE_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= tick ? '0 : pre + 17'd1;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [31:0] period, count;
    logic en, periodic, ie, flag;
    logic sel, ctrl_wr, stop, start, run_tick;
    assign sel      = write & cs & (addr[4:2] == 3'(g));
    assign ctrl_wr  = sel & (addr[1:0] == 2'd2);
    assign stop     = ctrl_wr & ~wr_data[0];
    assign start    = ctrl_wr & wr_data[0] & (~en | wr_data[2]);
    // a disable or restart on the same edge pre-empts the tick, so no expiry is seen
    assign run_tick = en & tick & ~stop & ~start;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        period   <= '0;
        count    <= '0;
        en       <= 1'b0;
        periodic <= 1'b0;
        ie       <= 1'b0;
        flag     <= 1'b0;
      end else begin
        if (sel && addr[1:0] == 2'd0) period <= wr_data;
        if (ctrl_wr) begin
          periodic <= wr_data[1];
          ie       <= wr_data[3];
        end
        if (stop) en <= 1'b0;
        else if (start) begin
          en <= period != '0;
          if (period != '0) count <= period;
        end else if (run_tick) begin
          if (count > 32'd1) count <= count - 32'd1;
          else begin
            count <= periodic ? period : '0;
            en    <= periodic && period != '0;
          end
        end
        if (run_tick && count == 32'd1) flag <= 1'b1;
        else if (sel && addr[1:0] == 2'd3 && wr_data[0]) flag <= 1'b0;
      end
    assign period_v[g]   = period;
    assign count_v[g]    = count;
    assign en_v[g]       = en;
    assign periodic_v[g] = periodic;
    assign ie_v[g]       = ie;
    assign flag_v[g]     = flag;
  end
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (addr[4:2] == 3'(i))
        rd_data = addr[1:0] == 2'd0 ? period_v[i] :
                  addr[1:0] == 2'd1 ? count_v[i] :
                  addr[1:0] == 2'd2 ? {28'd0, ie_v[i], periodic_v[i], 1'b0, en_v[i]} :
                                      {31'd0, flag_v[i]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq <= 1'b0;
    else irq <= |(flag_v & ie_v);
endmodule

// File: tb/tb_chu_timer_sched.sv
// tb_chu_timer_sched: two instances (prescale 1 and 4) on one shared bus, checked every cycle
// against a rule-level reference model plus directed schedule checks.
module tb_chu_timer_sched;
  logic clk = 0, rst_n = 0, cs = 0, read = 0, write = 0;
  logic [4:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd1, rd4;
  logic irq1, irq4;
  int tests = 0, fails = 0;
  always #50 clk = ~clk;
  chu_timer_sched #(.NUM_CH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd1), .irq(irq1));
  chu_timer_sched #(.NUM_CH(4), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd4), .irq(irq4));
  // reference model: index [instance][channel], instance 0 ticks every cycle, 1 every 4th
  logic [31:0] m_period [2][4];
  logic [31:0] m_count [2][4];
  bit m_en [2][4], m_per [2][4], m_ie [2][4], m_flag [2][4];
  bit m_irq [2];
  int pc [2];
  bit tk, hit;
  int r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        pc[m] = 0;
        m_irq[m] = 0;
        for (int c = 0; c < 4; c++) begin
          m_period[m][c] = 0; m_count[m][c] = 0;
          m_en[m][c] = 0; m_per[m][c] = 0; m_ie[m][c] = 0; m_flag[m][c] = 0;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        tk = pc[m] == (m == 1 ? 3 : 0);
        pc[m] = tk ? 0 : pc[m] + 1;
        m_irq[m] = 0;
        for (int c = 0; c < 4; c++) if (m_flag[m][c] && m_ie[m][c]) m_irq[m] = 1;
        for (int c = 0; c < 4; c++) begin
          hit = write && cs && (int'(addr[4:2]) == c);
          r = int'(addr[1:0]);
          if (hit && r == 3 && wr_data[0]) m_flag[m][c] = 0;
          if (hit && r == 2 && !wr_data[0]) m_en[m][c] = 0;
          else if (hit && r == 2 && (!m_en[m][c] || wr_data[2])) begin
            m_en[m][c] = m_period[m][c] != 0;
            if (m_period[m][c] != 0) m_count[m][c] = m_period[m][c];
          end else if (m_en[m][c] && tk) begin
            if (m_count[m][c] > 1) m_count[m][c] = m_count[m][c] - 1;
            else begin
              m_flag[m][c] = 1;
              if (m_per[m][c] && m_period[m][c] != 0) m_count[m][c] = m_period[m][c];
              else begin m_count[m][c] = 0; m_en[m][c] = 0; end
            end
          end
          if (hit && r == 2) begin m_per[m][c] = wr_data[1]; m_ie[m][c] = wr_data[3]; end
          if (hit && r == 0) m_period[m][c] = wr_data;
        end
      end
    end
  end
  function automatic logic [31:0] exp_rd(input int m, input int a);
    int ch = a >> 2;
    int rg = a & 3;
    if (ch >= 4) return 32'd0;
    if (rg == 0) return m_period[m][ch];
    if (rg == 1) return m_count[m][ch];
    if (rg == 2) return {28'd0, m_ie[m][ch], m_per[m][ch], 1'b0, m_en[m][ch]};
    return {31'd0, m_flag[m][ch]};
  endfunction
  function automatic int ad(input int ch, input int rg);
    return ch * 4 + rg;
  endfunction
  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, e);
    end
  endtask
  task automatic sweep();
    for (int a = 0; a < 32; a++) begin
      cs = 1; read = 1; addr = 5'(a); #1;
      ck($sformatf("model rd p1 a%0d", a), rd1, exp_rd(0, a));
      ck($sformatf("model rd p4 a%0d", a), rd4, exp_rd(1, a));
    end
    cs = 0; read = 0;
    ck("model irq p1", 32'(irq1), 32'(m_irq[0]));
    ck("model irq p4", 32'(irq4), 32'(m_irq[1]));
  endtask
  task automatic cyc(input logic w, input int a, input logic [31:0] d);
    cs = w; write = w; addr = 5'(a); wr_data = d;
    @(posedge clk); #1;
    cs = 0; write = 0;
    @(negedge clk);
    sweep();
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 32'd0);
  endtask
  task automatic rdv(input int m, input int a, output logic [31:0] v);
    cs = 1; read = 1; addr = 5'(a); #1;
    v = m == 1 ? rd4 : rd1;
    cs = 0; read = 0;
  endtask
  task automatic wait_flag(input int a, output int n);
    logic [31:0] v;
    n = 0; v = 0;
    while (v[0] !== 1'b1 && n < 100) begin
      idle(1); n++;
      rdv(1, a, v);
    end
    ck("t3 flag wait", 32'(v[0]), 32'd1);
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] v;
    int n, ch, rg;
    logic [31:0] d;
    idle(3);
    rst_n = 1;
    idle(2);
    // one-shot on ch0, prescale 1
    cyc(1'b1, ad(0, 0), 32'd5);
    cyc(1'b1, ad(0, 2), 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      rdv(0, ad(0, 3), v); ck("t2 flag early", v, 32'd0);
    end
    idle(1);
    rdv(0, ad(0, 3), v); ck("t2 flag", v, 32'd1);
    rdv(0, ad(0, 1), v); ck("t2 count", v, 32'd0);
    ck("t2 irq before", 32'(irq1), 32'd0);
    idle(1);
    ck("t2 irq", 32'(irq1), 32'd1);
    rdv(0, ad(0, 2), v); ck("t2 ctrl", v, 32'h8);
    cyc(1'b1, ad(0, 3), 32'd1);
    idle(1);
    ck("t2 irq cleared", 32'(irq1), 32'd0);
    // periodic on ch2, prescale 4
    cyc(1'b1, ad(2, 0), 32'd3);
    cyc(1'b1, ad(2, 2), 32'hB);
    wait_flag(ad(2, 3), n);
    cyc(1'b1, ad(2, 3), 32'd1);
    wait_flag(ad(2, 3), n);
    ck("t3 spacing", 32'(1 + n), 32'd12);
    cyc(1'b1, ad(2, 0), 32'd6);
    cyc(1'b1, ad(2, 3), 32'd1);
    wait_flag(ad(2, 3), n);
    ck("t3 old spacing", 32'(2 + n), 32'd12);
    cyc(1'b1, ad(2, 3), 32'd1);
    wait_flag(ad(2, 3), n);
    ck("t3 new spacing", 32'(1 + n), 32'd24);
    cyc(1'b1, ad(2, 2), 32'd0);
    // collisions on ch1, prescale 1
    cyc(1'b1, ad(1, 0), 32'd3);
    cyc(1'b1, ad(1, 2), 32'h1);
    idle(2);
    cyc(1'b1, ad(1, 3), 32'd1);
    rdv(0, ad(1, 3), v); ck("t4 w1c vs expiry", v, 32'd1);
    cyc(1'b1, ad(1, 3), 32'd1);
    cyc(1'b1, ad(1, 2), 32'h1);
    idle(2);
    cyc(1'b1, ad(1, 2), 32'h5);
    rdv(0, ad(1, 1), v); ck("t4 restart count", v, 32'd3);
    rdv(0, ad(1, 3), v); ck("t4 restart flag", v, 32'd0);
    cyc(1'b1, ad(1, 2), 32'd0);
    // edges
    cyc(1'b1, ad(3, 0), 32'd0);
    cyc(1'b1, ad(3, 2), 32'h1);
    rdv(0, ad(3, 2), v); ck("t5 zero period en", v, 32'd0);
    cyc(1'b1, ad(5, 0), 32'h1234);
    cyc(1'b1, ad(5, 2), 32'h1);
    rdv(0, ad(5, 0), v); ck("t5 oob read", v, 32'd0);
    cyc(1'b1, ad(3, 0), 32'hFFFF_FFFF);
    cyc(1'b1, ad(3, 2), 32'h1);
    idle(1);
    rdv(0, ad(3, 1), v); ck("t5 max period dec", v, 32'hFFFF_FFFE);
    cyc(1'b1, ad(3, 2), 32'd0);
    // all channels at once; ch3 has interrupts disabled
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, ad(c, 2), 32'd0);
      cyc(1'b1, ad(c, 3), 32'd1);
      cyc(1'b1, ad(c, 0), 32'(c + 2));
    end
    for (int c = 0; c < 4; c++) cyc(1'b1, ad(c, 2), c == 3 ? 32'h3 : 32'hB);
    idle(60);
    for (int c = 0; c < 3; c++) cyc(1'b1, ad(c, 2), 32'd0);
    for (int c = 0; c < 3; c++) cyc(1'b1, ad(c, 3), 32'd1);
    idle(2);
    ck("t6 irq ie0 only p1", 32'(irq1), 32'd0);
    ck("t6 irq ie0 only p4", 32'(irq4), 32'd0);
    rdv(0, ad(3, 3), v); ck("t6 ch3 flag", v, 32'd1);
    cyc(1'b1, ad(3, 2), 32'd0);
    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ch = $urandom_range(0, 4);
      rg = $urandom_range(0, 3);
      d = rg == 0 ? 32'($urandom_range(0, 6)) : 32'($urandom_range(0, 15));
      cyc($urandom_range(0, 3) == 0, ad(ch, rg), d);
    end
    // reset mid-run
    cyc(1'b1, ad(0, 0), 32'd2);
    cyc(1'b1, ad(0, 2), 32'hB);
    idle(3);
    @(negedge clk);
    rst_n = 0; #1;
    sweep();
    ck("t1 irq in reset", 32'(irq1), 32'd0);
    idle(2);
    rst_n = 1;
    idle(100);
    for (int c = 0; c < 4; c++) begin
      rdv(0, ad(c, 3), v); ck("t1 flag after reset", v, 32'd0);
    end
    ck("t1 irq after reset", 32'(irq1), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
